// File: rtl/axi_wr_arb_pkg.sv
// Shared widths and payload field layout for the slave-side write arbiter.
// AW payload is {awid, awlen, awaddr}; W payload is {wlast, wstrb, wdata}.
package axi_wr_arb_pkg;

    localparam int AWLEN_W = 4;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int aw_len_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int aw_id_lsb(input int addr_w);
        return addr_w + AWLEN_W;
    endfunction

    function automatic int awp_w(input int id_w, input int addr_w);
        return id_w + AWLEN_W + addr_w;
    endfunction

    function automatic int w_strb_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int wp_w(input int data_w);
        return 1 + data_w / 8 + data_w;
    endfunction

    // s_awpld is {idx, awid, awlen, awaddr}
    function automatic int saw_idx_lsb(input int id_w, input int addr_w);
        return id_w + AWLEN_W + addr_w;
    endfunction

endpackage

// File: rtl/axi_wr_order_fifo.sv
// In-order index FIFO recording which master owns each granted burst.
// Push into full and pop from empty are ignored.
module axi_wr_order_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/axi_slv_wr_arb.sv
// Shares one slave AW/W/B port among MST_NUM masters: round-robin AW,
// W steered in AW grant order, B routed by index bits on the slave ID.
module axi_slv_wr_arb
    import axi_wr_arb_pkg::*;
#(
    parameter int  MST_NUM    = 4,
    parameter int  AXI_ID_W   = 4,
    parameter int  AXI_ADDR_W = 32,
    parameter int  AXI_DATA_W = 32,
    parameter int  OSTD_NUM   = 4,
    localparam int IDX_W      = idx_w(MST_NUM),
    localparam int SID_W      = AXI_ID_W + IDX_W,
    localparam int AWP_W      = awp_w(AXI_ID_W, AXI_ADDR_W),
    localparam int WP_W       = wp_w(AXI_DATA_W),
    localparam int SAWP_W     = SID_W + AWLEN_W + AXI_ADDR_W
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [MST_NUM-1:0]       m_awvalid,
    output logic [MST_NUM-1:0]       m_awready,
    input  logic [MST_NUM*AWP_W-1:0] m_awpld,
    input  logic [MST_NUM-1:0]       m_wvalid,
    output logic [MST_NUM-1:0]       m_wready,
    input  logic [MST_NUM*WP_W-1:0]  m_wpld,
    output logic [MST_NUM-1:0]       m_bvalid,
    input  logic [MST_NUM-1:0]       m_bready,
    output logic [AXI_ID_W-1:0]      m_bid,
    output logic [1:0]               m_bresp,
    output logic                     s_awvalid,
    input  logic                     s_awready,
    output logic [SAWP_W-1:0]        s_awpld,
    output logic                     s_wvalid,
    input  logic                     s_wready,
    output logic [WP_W-1:0]          s_wpld,
    input  logic                     s_bvalid,
    output logic                     s_bready,
    input  logic [SID_W-1:0]         s_bid,
    input  logic [1:0]               s_bresp
);

    localparam int CNT_W = $clog2(OSTD_NUM + 1);

    logic [IDX_W-1:0]       rr;
    logic [2*MST_NUM-1:0]   rot;
    logic [IDX_W:0]         sum;
    logic                   gnt_hit;
    logic [IDX_W-1:0]       gnt_idx;
    logic [AWP_W-1:0]       gnt_pld;
    logic                   slot_free;
    logic                   grant;
    logic [IDX_W-1:0]       fifo_head;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   w_pop;
    logic [IDX_W-1:0]       b_idx;
    logic                   unused_cnt;

    assign slot_free  = !s_awvalid || s_awready;
    assign unused_cnt = ^fifo_cnt;

    // Rotate so bit 0 is the master at rr; first set bit is the winner.
    always_comb begin
        rot     = {m_awvalid, m_awvalid} >> rr;
        gnt_hit = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int i = 0; i < MST_NUM; i++) begin
            if (!gnt_hit && rot[i]) begin
                gnt_hit = 1'b1;
                sum     = (IDX_W+1)'(rr) + (IDX_W+1)'(i);
                if (sum >= (IDX_W+1)'(MST_NUM))
                    sum = sum - (IDX_W+1)'(MST_NUM);
                gnt_idx = sum[IDX_W-1:0];
            end
        end
    end

    assign grant = aresetn && slot_free && gnt_hit && !fifo_full;

    always_comb begin
        m_awready = '0;
        gnt_pld   = '0;
        for (int k = 0; k < MST_NUM; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                m_awready[k] = grant;
                gnt_pld      = m_awpld[k*AWP_W +: AWP_W];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_awvalid <= 1'b0;
            s_awpld   <= '0;
            rr        <= '0;
        end else if (grant) begin
            s_awvalid <= 1'b1;
            s_awpld   <= {gnt_idx, gnt_pld};
            rr        <= (gnt_idx == IDX_W'(MST_NUM - 1)) ?
                         '0 : gnt_idx + IDX_W'(1);
        end else if (slot_free) begin
            s_awvalid <= 1'b0;
        end
    end

    axi_wr_order_fifo #(
        .W     (IDX_W),
        .DEPTH (OSTD_NUM)
    ) u_order (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (grant),
        .din     (gnt_idx),
        .pop     (w_pop),
        .head    (fifo_head),
        .count   (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        s_wvalid = 1'b0;
        s_wpld   = '0;
        m_wready = '0;
        for (int k = 0; k < MST_NUM; k++) begin
            if (!fifo_empty && fifo_head == IDX_W'(k)) begin
                s_wvalid    = m_wvalid[k];
                s_wpld      = m_wpld[k*WP_W +: WP_W];
                m_wready[k] = s_wready;
            end
        end
    end

    assign w_pop = s_wvalid && s_wready && s_wpld[WP_W-1];

    assign b_idx   = s_bid[SID_W-1:AXI_ID_W];
    assign m_bid   = s_bid[AXI_ID_W-1:0];
    assign m_bresp = s_bresp;

    // Responses for an index with no master are sunk.
    always_comb begin
        m_bvalid = '0;
        s_bready = 1'b1;
        for (int k = 0; k < MST_NUM; k++) begin
            if (b_idx == IDX_W'(k)) begin
                m_bvalid[k] = s_bvalid;
                s_bready    = m_bready[k];
            end
        end
    end

endmodule
